// File: rtl/id_ex_stage_pkg.sv
// Shared widths, the zero-register constant and the ID/EX register record.
// Imported by the ID/EX stage, its hazard detector and the forwarding unit.
package id_ex_stage_pkg;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned ALU_OP_W   = 4;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'b00000;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rs;
    logic [REG_ADDR_W-1:0] rt;
    logic [REG_ADDR_W-1:0] write_reg_addr;
    logic [DATA_W-1:0]     read_data_1;
    logic [DATA_W-1:0]     read_data_2;
    logic [DATA_W-1:0]     imm;
    logic                  reg_write;
    logic                  mem_read;
    logic                  mem_write;
    logic                  mem_to_reg;
    logic                  alu_src;
    logic [ALU_OP_W-1:0]   alu_op;
  } id_ex_t;

  // All-zero record: no valid, no side effects, no forwarding match.
  localparam id_ex_t BUBBLE = '0;

endpackage

// File: rtl/id_ex_stage_if.sv
// ID -> EX pipeline bus: decoded ID fields in, registered EX fields and stall out.
// The stage uses the slave modport; the decode side drives the master modport.
interface id_ex_stage_if;
  import id_ex_stage_pkg::*;

  logic                  id_valid;
  logic [REG_ADDR_W-1:0] id_rs;
  logic [REG_ADDR_W-1:0] id_rt;
  logic [REG_ADDR_W-1:0] id_rd;
  logic                  id_uses_rs;
  logic                  id_uses_rt;
  logic [DATA_W-1:0]     id_read_data_1;
  logic [DATA_W-1:0]     id_read_data_2;
  logic [DATA_W-1:0]     id_imm;
  logic                  id_reg_write;
  logic                  id_mem_read;
  logic                  id_mem_write;
  logic                  id_mem_to_reg;
  logic                  id_alu_src;
  logic                  id_reg_dst;
  logic [ALU_OP_W-1:0]   id_alu_op;
  logic                  flush;
  logic                  ex_hold;

  logic                  stall;
  logic                  id_ex_valid;
  logic [REG_ADDR_W-1:0] id_ex_rs;
  logic [REG_ADDR_W-1:0] id_ex_rt;
  logic [REG_ADDR_W-1:0] id_ex_write_reg_addr;
  logic [DATA_W-1:0]     id_ex_read_data_1;
  logic [DATA_W-1:0]     id_ex_read_data_2;
  logic [DATA_W-1:0]     id_ex_imm;
  logic                  id_ex_reg_write;
  logic                  id_ex_mem_read;
  logic                  id_ex_mem_write;
  logic                  id_ex_mem_to_reg;
  logic                  id_ex_alu_src;
  logic [ALU_OP_W-1:0]   id_ex_alu_op;

  modport master (
    output id_valid, id_rs, id_rt, id_rd, id_uses_rs, id_uses_rt,
    output id_read_data_1, id_read_data_2, id_imm,
    output id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_alu_src, id_reg_dst,
    output id_alu_op, flush, ex_hold,
    input  stall, id_ex_valid, id_ex_rs, id_ex_rt, id_ex_write_reg_addr,
    input  id_ex_read_data_1, id_ex_read_data_2, id_ex_imm,
    input  id_ex_reg_write, id_ex_mem_read, id_ex_mem_write, id_ex_mem_to_reg, id_ex_alu_src,
    input  id_ex_alu_op
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_rd, id_uses_rs, id_uses_rt,
    input  id_read_data_1, id_read_data_2, id_imm,
    input  id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_alu_src, id_reg_dst,
    input  id_alu_op, flush, ex_hold,
    output stall, id_ex_valid, id_ex_rs, id_ex_rt, id_ex_write_reg_addr,
    output id_ex_read_data_1, id_ex_read_data_2, id_ex_imm,
    output id_ex_reg_write, id_ex_mem_read, id_ex_mem_write, id_ex_mem_to_reg, id_ex_alu_src,
    output id_ex_alu_op
  );

endinterface

// File: rtl/id_ex_stage_hazard_detect.sv
// Combinational load-use hazard detection and stall generation for the ID/EX stage.
module id_ex_stage_hazard_detect
  import id_ex_stage_pkg::*;
(
  input  logic                  id_valid_i,
  input  logic [REG_ADDR_W-1:0] id_rs_i,
  input  logic [REG_ADDR_W-1:0] id_rt_i,
  input  logic                  id_uses_rs_i,
  input  logic                  id_uses_rt_i,
  input  logic                  ex_valid_i,
  input  logic                  ex_mem_read_i,
  input  logic [REG_ADDR_W-1:0] ex_write_reg_addr_i,
  input  logic                  ex_hold_i,
  output logic                  load_use_o,
  output logic                  stall_o
);

  logic rs_match;
  logic rt_match;

  always_comb begin
    rs_match   = id_uses_rs_i && (id_rs_i == ex_write_reg_addr_i);
    rt_match   = id_uses_rt_i && (id_rt_i == ex_write_reg_addr_i);
    // $0 is hardwired, so a load targeting it never creates a dependency.
    load_use_o = id_valid_i && ex_valid_i && ex_mem_read_i &&
                 (ex_write_reg_addr_i != REG_ZERO) && (rs_match || rt_match);
    stall_o    = load_use_o || ex_hold_i;
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with bubble insertion (flush, load-use) and EX hold,
// plus a saturating count of load-use stall cycles.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  id_ex_stage_if.slave     bus,
  output logic [CNT_W-1:0] load_use_stalls
);

  id_ex_t           ex_q, ex_d, id_pkt;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             load_use;
  logic             stall;

  id_ex_stage_hazard_detect u_hazard_detect (
    .id_valid_i          (bus.id_valid),
    .id_rs_i             (bus.id_rs),
    .id_rt_i             (bus.id_rt),
    .id_uses_rs_i        (bus.id_uses_rs),
    .id_uses_rt_i        (bus.id_uses_rt),
    .ex_valid_i          (ex_q.valid),
    .ex_mem_read_i       (ex_q.mem_read),
    .ex_write_reg_addr_i (ex_q.write_reg_addr),
    .ex_hold_i           (bus.ex_hold),
    .load_use_o          (load_use),
    .stall_o             (stall)
  );

  always_comb begin
    id_pkt.valid          = bus.id_valid;
    id_pkt.rs             = bus.id_rs;
    id_pkt.rt             = bus.id_rt;
    id_pkt.write_reg_addr = bus.id_reg_dst ? bus.id_rd : bus.id_rt;
    id_pkt.read_data_1    = bus.id_read_data_1;
    id_pkt.read_data_2    = bus.id_read_data_2;
    id_pkt.imm            = bus.id_imm;
    id_pkt.reg_write      = bus.id_reg_write;
    id_pkt.mem_read       = bus.id_mem_read;
    id_pkt.mem_write      = bus.id_mem_write;
    id_pkt.mem_to_reg     = bus.id_mem_to_reg;
    id_pkt.alu_src        = bus.id_alu_src;
    id_pkt.alu_op         = bus.id_alu_op;
  end

  // Hold beats flush: the branch unit keeps flush up until EX releases.
  always_comb begin
    ex_d = ex_q;
    if (bus.ex_hold) begin
      ex_d = ex_q;
    end else if (bus.flush || load_use) begin
      ex_d = BUBBLE;
    end else begin
      ex_d = id_pkt;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (load_use && !bus.ex_hold && !bus.flush && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q  <= BUBBLE;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      cnt_q <= cnt_d;
    end
  end

  assign load_use_stalls          = cnt_q;
  assign bus.stall                = stall;
  assign bus.id_ex_valid          = ex_q.valid;
  assign bus.id_ex_rs             = ex_q.rs;
  assign bus.id_ex_rt             = ex_q.rt;
  assign bus.id_ex_write_reg_addr = ex_q.write_reg_addr;
  assign bus.id_ex_read_data_1    = ex_q.read_data_1;
  assign bus.id_ex_read_data_2    = ex_q.read_data_2;
  assign bus.id_ex_imm            = ex_q.imm;
  assign bus.id_ex_reg_write      = ex_q.reg_write;
  assign bus.id_ex_mem_read       = ex_q.mem_read;
  assign bus.id_ex_mem_write      = ex_q.mem_write;
  assign bus.id_ex_mem_to_reg     = ex_q.mem_to_reg;
  assign bus.id_ex_alu_src        = ex_q.alu_src;
  assign bus.id_ex_alu_op         = ex_q.alu_op;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed table-driven bench for id_ex_stage (CNT_W = 4 to reach saturation quickly).
module tb_id_ex_stage;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] load_use_stalls;
  int         checks = 0;
  int         errors = 0;

  id_ex_stage_if bus ();

  id_ex_stage #(.CNT_W(4)) dut (
    .clk             (clk),
    .reset           (reset),
    .bus             (bus),
    .load_use_stalls (load_use_stalls)
  );

  always #5 clk = ~clk;

  // Derived inputs: d2 = ~d1, imm = d1 ^ 'h55, alu_op = d1[3:0], mem_write = d1[4],
  // mem_to_reg = alu_src = mem_read. A zero expected d1 means a bubble (all data 0).
  typedef struct {
    logic        v;
    logic [4:0]  rs, rt, rd;
    logic        urs, urt, mr, rw, rdst;
    logic [31:0] d1;
    logic        fl, hold;
    logic        e_stall, e_valid;
    logic [4:0]  e_rs, e_rt, e_wra;
    logic        e_mr, e_rw;
    logic [31:0] e_d1;
    logic [3:0]  e_cnt;
  } vec_t;

  vec_t vecs[17];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    bus.id_valid       = t.v;
    bus.id_rs          = t.rs;
    bus.id_rt          = t.rt;
    bus.id_rd          = t.rd;
    bus.id_uses_rs     = t.urs;
    bus.id_uses_rt     = t.urt;
    bus.id_read_data_1 = t.d1;
    bus.id_read_data_2 = ~t.d1;
    bus.id_imm         = t.d1 ^ 32'h55;
    bus.id_reg_write   = t.rw;
    bus.id_mem_read    = t.mr;
    bus.id_mem_write   = t.d1[4];
    bus.id_mem_to_reg  = t.mr;
    bus.id_alu_src     = t.mr;
    bus.id_reg_dst     = t.rdst;
    bus.id_alu_op      = t.d1[3:0];
    bus.flush          = t.fl;
    bus.ex_hold        = t.hold;
  endtask

  task automatic check_regs(input vec_t t, input string nm);
    logic [31:0] e_d2, e_imm, e_op, e_mw;
    e_d2  = (t.e_d1 == 0) ? 32'h0 : ~t.e_d1;
    e_imm = (t.e_d1 == 0) ? 32'h0 : (t.e_d1 ^ 32'h55);
    e_op  = {28'h0, t.e_d1[3:0]};
    e_mw  = {31'h0, t.e_d1[4]};
    chk({nm, " valid"}, {31'h0, bus.id_ex_valid}, {31'h0, t.e_valid});
    chk({nm, " rs"}, {27'h0, bus.id_ex_rs}, {27'h0, t.e_rs});
    chk({nm, " rt"}, {27'h0, bus.id_ex_rt}, {27'h0, t.e_rt});
    chk({nm, " wra"}, {27'h0, bus.id_ex_write_reg_addr}, {27'h0, t.e_wra});
    chk({nm, " d1"}, bus.id_ex_read_data_1, t.e_d1);
    chk({nm, " d2"}, bus.id_ex_read_data_2, e_d2);
    chk({nm, " imm"}, bus.id_ex_imm, e_imm);
    chk({nm, " ctl"}, {27'h0, bus.id_ex_reg_write, bus.id_ex_mem_read, bus.id_ex_mem_write,
                       bus.id_ex_mem_to_reg, bus.id_ex_alu_src},
                      {27'h0, t.e_rw, t.e_mr, e_mw[0], t.e_mr, t.e_mr});
    chk({nm, " alu_op"}, {28'h0, bus.id_ex_alu_op}, e_op);
    chk({nm, " cnt"}, {28'h0, load_use_stalls}, {28'h0, t.e_cnt});
  endtask

  task automatic apply(input vec_t t, input string nm);
    @(negedge clk);
    drive(t);
    #1;
    chk({nm, " stall"}, {31'h0, bus.stall}, {31'h0, t.e_stall});
    @(posedge clk);
    #1;
    check_regs(t, nm);
  endtask

  initial begin
    vec_t lw8, use8, z;
    int   exp_cnt;

    //          v rs rt rd urs urt mr rw rdst d1     fl hd  st vl ers ert ewra emr erw ed1  cnt
    vecs[0]  = '{1, 2, 8, 0, 1, 0, 1, 1, 0, 'h100, 0, 0,  0, 1, 2, 8, 8, 1, 1, 'h100, 0};
    vecs[1]  = '{1, 8, 9, 10, 1, 1, 0, 1, 1, 'h211, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1};
    vecs[2]  = '{1, 8, 9, 10, 1, 1, 0, 1, 1, 'h211, 0, 0, 0, 1, 8, 9, 10, 0, 1, 'h211, 1};
    vecs[3]  = '{1, 3, 0, 0, 1, 0, 1, 1, 0, 'h300, 0, 0,  0, 1, 3, 0, 0, 1, 1, 'h300, 1};
    vecs[4]  = '{1, 0, 0, 11, 1, 1, 0, 1, 1, 'h402, 0, 0, 0, 1, 0, 0, 11, 0, 1, 'h402, 1};
    vecs[5]  = '{1, 4, 9, 0, 1, 0, 1, 1, 0, 'h500, 0, 0,  0, 1, 4, 9, 9, 1, 1, 'h500, 1};
    vecs[6]  = '{1, 5, 9, 12, 1, 1, 0, 1, 1, 'h613, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1};
    vecs[7]  = '{1, 1, 7, 0, 1, 0, 1, 1, 0, 'h700, 0, 0,  0, 1, 1, 7, 7, 1, 1, 'h700, 1};
    vecs[8]  = '{1, 6, 7, 13, 1, 0, 0, 1, 1, 'h800, 0, 0, 0, 1, 6, 7, 13, 0, 1, 'h800, 1};
    vecs[9]  = vecs[7];
    vecs[10] = '{0, 7, 7, 0, 1, 1, 0, 0, 0, 'h900, 0, 0,  0, 0, 7, 7, 7, 0, 0, 'h900, 1};
    vecs[11] = '{1, 1, 5, 0, 1, 0, 1, 1, 0, 'hA00, 0, 0,  0, 1, 1, 5, 5, 1, 1, 'hA00, 1};
    vecs[12] = '{1, 5, 6, 14, 1, 1, 0, 1, 1, 'hB07, 1, 1, 1, 1, 1, 5, 5, 1, 1, 'hA00, 1};
    vecs[13] = vecs[12];
    vecs[14] = vecs[12];
    vecs[15] = '{1, 5, 6, 14, 1, 1, 0, 1, 1, 'hB07, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1};
    vecs[16] = '{1, 5, 6, 14, 1, 1, 0, 1, 1, 'hB07, 0, 0, 0, 1, 5, 6, 14, 0, 1, 'hB07, 1};

    // Reset with every ID input nonzero (hold low so stall reflects only load-use).
    z = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    reset = 1'b1;
    drive('{1, 8, 8, 8, 1, 1, 1, 1, 1, 'hFFFF_FFFF, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
    repeat (2) @(posedge clk);
    #1;
    check_regs(z, "reset");
    chk("reset stall", {31'h0, bus.stall}, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 17; i++) begin
      apply(vecs[i], $sformatf("vec%0d", i));
    end

    // Drive the saturating counter past its 4-bit limit.
    lw8  = vecs[0];
    use8 = vecs[1];
    exp_cnt = 1;
    for (int k = 0; k < 16; k++) begin
      lw8.e_cnt = exp_cnt[3:0];
      apply(lw8, $sformatf("sat_lw%0d", k));
      exp_cnt = (exp_cnt < 15) ? exp_cnt + 1 : 15;
      use8.e_cnt = exp_cnt[3:0];
      apply(use8, $sformatf("sat_use%0d", k));
    end

    // Reset overrides a pending load-use and clears the counter.
    lw8.e_cnt = 4'd15;
    apply(lw8, "pre_rst_lw");
    @(negedge clk);
    drive(use8);
    reset = 1'b1;
    #1;
    chk("pre_rst stall", {31'h0, bus.stall}, 32'h1);
    @(posedge clk);
    #1;
    check_regs(z, "reset2");
    reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
